// File: rtl/multi_return_search.sv
// multi_return_search: table-search engine with early-return (first-match)
// and full-scan (count) modes. One table entry is compared per cycle
// against a key captured on start; the result is presented with a
// one-cycle done pulse and held until the next accepted start.
module multi_return_search #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [WIDTH-1:0] key,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] out1
);

  localparam logic [7:0] ST_INITIAL = 8'd0;
  localparam logic [7:0] ST_IDLE    = 8'd1;
  localparam logic [7:0] ST_SCAN    = 8'd2;

  logic [7:0]       fsm_state_q, fsm_state_d;
  logic [WIDTH-1:0] table_q [DEPTH];
  logic [WIDTH-1:0] table_d [DEPTH];
  logic [WIDTH-1:0] key_q, key_d;
  logic             mode_q, mode_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [IDXW:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic [WIDTH-1:0] out1_q, out1_d;

  // Compare path: the registered table value is used, so a same-cycle
  // write to the compared entry is only seen by later comparisons.
  logic             hit_s;
  logic             last_s;
  logic             early_s;
  logic [IDXW:0]    idx_p1_s;
  logic [IDXW:0]    cnt_fin_s;

  assign hit_s     = (table_q[idx_q] == key_q);
  assign last_s    = (idx_q == IDXW'(DEPTH - 1));
  assign early_s   = (!mode_q) && hit_s;
  assign idx_p1_s  = {1'b0, idx_q} + {{IDXW{1'b0}}, 1'b1};
  assign cnt_fin_s = cnt_q + {{IDXW{1'b0}}, hit_s};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_state_q <= ST_INITIAL;
    end else begin
      fsm_state_q <= fsm_state_d;
    end
  end

  // Next-state logic: initial -> idle, idle -> scan on start, scan returns
  // to idle on an early hit or after the last entry.
  always_comb begin
    fsm_state_d = fsm_state_q;
    case (fsm_state_q)
      ST_INITIAL: fsm_state_d = ST_IDLE;
      ST_IDLE: begin
        if (start) begin
          fsm_state_d = ST_SCAN;
        end else begin
          fsm_state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (early_s || last_s) begin
          fsm_state_d = ST_IDLE;
        end else begin
          fsm_state_d = ST_SCAN;
        end
      end
      default: fsm_state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; done defaults low so it pulses.
  always_comb begin
    key_d   = key_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    found_d = found_q;
    out1_d  = out1_q;
    case (fsm_state_q)
      ST_INITIAL: begin
        busy_d = 1'b0;
      end
      ST_IDLE: begin
        if (start) begin
          key_d   = key;
          mode_d  = mode;
          idx_d   = {IDXW{1'b0}};
          cnt_d   = {(IDXW+1){1'b0}};
          busy_d  = 1'b1;
          found_d = 1'b0;
          out1_d  = {WIDTH{1'b0}};
        end else begin
          busy_d = busy_q;
        end
      end
      ST_SCAN: begin
        if (early_s) begin
          out1_d  = WIDTH'(idx_p1_s);
          found_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (last_s) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          cnt_d  = cnt_fin_s;
          if (mode_q) begin
            out1_d  = WIDTH'(cnt_fin_s);
            found_d = (cnt_fin_s != {(IDXW+1){1'b0}});
          end else begin
            out1_d  = {WIDTH{1'b0}};
            found_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_fin_s;
          idx_d = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Table write port, open in every state.
  always_comb begin
    table_d = table_q;
    if (wr_en) begin
      table_d[wr_addr] = wr_data;
    end else begin
      table_d[wr_addr] = table_q[wr_addr];
    end
  end

  // Datapath, table and output registers; reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q   <= {WIDTH{1'b0}};
      mode_q  <= 1'b0;
      idx_q   <= {IDXW{1'b0}};
      cnt_q   <= {(IDXW+1){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      out1_q  <= {WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      key_q   <= key_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      out1_q  <= out1_d;
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= table_d[i];
      end
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign found = found_q;
  assign out1  = out1_q;

endmodule

// File: tb/tb_multi_return_search.sv
// Directed + randomized bench for multi_return_search with a
// table-level reference model.
module tb_multi_return_search;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int IDXW  = 3;

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic [IDXW-1:0]  wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic [WIDTH-1:0] key;
  logic             mode;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] out1;

  int vec;
  int miss;
  logic [WIDTH-1:0] tbl [DEPTH];

  multi_return_search #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .key(key), .mode(mode),
    .busy(busy), .done(done), .found(found), .out1(out1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what the search should return for the current table.
  task automatic model(input logic [WIDTH-1:0] k, input logic m,
                       output int lat, output logic [WIDTH-1:0] res,
                       output logic fnd);
    int n;
    int first;
    n = 0;
    first = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (tbl[i] == k) begin
        n++;
        if (first < 0) first = i;
      end
    end
    if (!m && first >= 0) begin
      lat = first + 1; res = WIDTH'(first + 1); fnd = 1'b1;
    end else if (!m) begin
      lat = DEPTH; res = '0; fnd = 1'b0;
    end else begin
      lat = DEPTH; res = WIDTH'(n); fnd = (n != 0);
    end
  endtask

  task automatic write_entry(input int a, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_addr = IDXW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    tbl[a] = d;
  endtask

  // One search; optional start pulse and write at given cycle numbers
  // (cycle c = the c-th edge after the start edge).
  task automatic run_search(input logic [WIDTH-1:0] k, input logic m,
                            input int pulse_at, input int wr_at,
                            input int wr_a, input logic [WIDTH-1:0] wr_d);
    int lat;
    logic [WIDTH-1:0] res;
    logic fnd;
    bit got;
    model(k, m, lat, res, fnd);
    start = 1'b1; key = k; mode = m;
    tick();
    start = 1'b0; key = $urandom; mode = $urandom_range(0, 1);
    check("busy_after_start", {31'b0, busy}, 32'd1);
    check("done_after_start", {31'b0, done}, 32'd0);
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      start = (c == pulse_at);
      if (c == wr_at) begin
        wr_en = 1'b1; wr_addr = IDXW'(wr_a); wr_data = wr_d;
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      if (c == wr_at) tbl[wr_a] = wr_d;
      if (done) begin
        got = 1'b1;
        check("latency", WIDTH'(c), WIDTH'(lat));
        check("out1", out1, res);
        check("found", {31'b0, found}, {31'b0, fnd});
        check("busy_at_done", {31'b0, busy}, 32'd0);
      end else begin
        check("busy_scan", {31'b0, busy}, 32'd1);
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    tick();
    check("done_single", {31'b0, done}, 32'd0);
    check("out1_held", out1, res);
  endtask

  initial begin
    vec = 0; miss = 0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; key = '0; mode = 1'b0;
    for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_found", {31'b0, found}, 32'd0);
    check("rst_out1", out1, 32'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    tick();
    write_entry(0, 32'd5); write_entry(1, 32'd7);
    write_entry(2, 32'd9); write_entry(3, 32'd7);
    write_entry(7, 32'd3);

    run_search(32'd7, 1'b0, 0, 0, 0, '0);
    run_search(32'd7, 1'b1, 0, 0, 0, '0);
    run_search(32'd0, 1'b1, 0, 0, 0, '0);
    run_search(32'd42, 1'b0, 3, 0, 0, '0);
    run_search(32'd3, 1'b0, 0, 8, 7, 32'd1);
    check("tbl7_model", tbl[7], 32'd1);
    run_search(32'd3, 1'b0, 0, 0, 0, '0);

    // Asynchronous reset in the middle of a scan.
    start = 1'b1; key = 32'd0; mode = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_found", {31'b0, found}, 32'd0);
    check("arst_out1", out1, 32'd0);
    for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_done", {31'b0, done}, 32'd0);
    end
    #2 reset = 1'b0;
    tick();
    check("post_rst_done", {31'b0, done}, 32'd0);
    run_search(32'd0, 1'b1, 0, 0, 0, '0);

    // Back-to-back: start held through the done cycle.
    write_entry(0, 32'd5);
    start = 1'b1; key = 32'd5; mode = 1'b0;
    tick();
    check("b2b_busy1", {31'b0, busy}, 32'd1);
    tick();
    check("b2b_done1", {31'b0, done}, 32'd1);
    check("b2b_out1a", out1, 32'd1);
    check("b2b_found1", {31'b0, found}, 32'd1);
    tick();
    start = 1'b0;
    check("b2b_gap", {31'b0, done}, 32'd0);
    check("b2b_busy2", {31'b0, busy}, 32'd1);
    check("b2b_cleared", out1, 32'd0);
    tick();
    check("b2b_done2", {31'b0, done}, 32'd1);
    check("b2b_out1b", out1, 32'd1);
    tick();
    check("b2b_end", {31'b0, done}, 32'd0);

    // Randomized searches against the model.
    for (int r = 0; r < 25; r++) begin
      for (int w = 0; w < 3; w++) begin
        write_entry($urandom_range(0, DEPTH - 1), WIDTH'($urandom_range(0, 3)));
      end
      run_search(WIDTH'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                 0, 0, 0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/multi_return_search.md
# multi_return_search

Parametrised table-search engine built as a compiler-style multi-state FSM, generalising the single-function conditional-return test block to a looping function with several return points. The block holds a DEPTH-entry table, accepts a key on `start`, and scans one entry per cycle. In first-match mode it returns early at the first hit; in count mode it scans the full table. The result is delivered with a one-cycle `done` pulse. It sits beside the generated FSM blocks as the reference loop/early-return unit for the V# back end.

## Interface
- `WIDTH`, 32: data, key and result width; must satisfy WIDTH > $clog2(DEPTH)+1.
- `DEPTH`, 8: number of table entries; power of two, ≥2.
- `IDXW`, $clog2(DEPTH): derived address width; not to be overridden.
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; returns the block to `__initial`.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  IDXW  table write address.
- `wr_data`  in  WIDTH  table write data.
- `start`  in  1  request; sampled only in `__Idle`.
- `key`  in  WIDTH  search key; captured with `start`.
- `mode`  in  1  0 = first-match (early return), 1 = count matches; captured with `start`.
- `busy`  out  1  high while a search is in progress.
- `done`  out  1  one-cycle result-valid pulse.
- `found`  out  1  at least one match occurred; valid with `done`, held until next accepted `start`.
- `out1`  out  WIDTH  result; valid with `done`, held until next accepted `start`.

## Operation
- State register `fsmState`, 8 bits. States: `__initial`=0, `__Idle`=1, `__Scan`=2.
- Reset (async) forces:
  - `fsmState`=`__initial`, all outputs 0.
  - Key/mode/index/count registers 0.
  - All table entries 0.
- `__initial`: outputs stay 0; next state is `__Idle` unconditionally.
- `__Idle` with `start`=1:
  - capture `key` and `mode`; index=0, count=0.
  - `busy`<=1, `found`<=0, `out1`<=0.
  - next state `__Scan`.
- `__Idle` with `start`=0: hold.
- `__Scan`: compare table[index] with the captured key.
  - mode 0, match: `out1`<=index+1, `found`<=1, `done`<=1, `busy`<=0, go `__Idle` (early return).
  - mode 1, match: count increments.
  - index==DEPTH-1 without an early return: `done`<=1, `busy`<=0, go `__Idle`.
    - mode 0: `out1`<=0, `found`<=0.
    - mode 1: `out1`<=final count including this cycle's match, zero-extended; `found`<=(final count≠0).
  - otherwise: index increments.
- `done` is cleared on the edge after it is set, unless it is set again that edge.
- Table writes are accepted in every state, including `__initial` after reset.
- A write to the entry being compared in the same cycle: the comparison uses the old value (read-before-write).
- `start` is ignored outside `__Idle`. Captured key/mode are unaffected by input changes during a scan.
- Arithmetic: index is IDXW bits and never wraps, because the scan stops at DEPTH-1. Count is IDXW+1 bits (maximum DEPTH).

## Timing
- `start` sampled at edge T (state `__Idle`): `busy`=1 after T.
- Mode 0, first match at index i: entry i compared at edge T+1+i; `done`/`out1`/`found` visible after that edge. Latency is i+1 cycles after T.
- No match, or mode 1: `done` after edge T+DEPTH.
- Back-to-back: `start` held high during the `done` cycle is accepted at the next edge (state is `__Idle`). `done` drops at that edge, `busy` rises.
- Reset mid-scan: outputs clear immediately, without waiting for a clock. No `done` is issued for the aborted request. Table contents are cleared.
- After reset deassertion: first edge → `__Idle`. `start` is accepted from the second edge onward.

## Test plan
- Reset, then write table = {5,7,9,7,0,0,0,3}. `start`, key=7, mode=0 → `done` 2 cycles after the start edge; `out1`=2, `found`=1, `busy` high exactly 2 cycles.
- Same table, key=7, mode=1 → `done` 8 cycles after the start edge; `out1`=2, `found`=1. Key=0, mode=1 → `out1`=3.
- Key=42, mode=0 → `done` after 8 cycles; `out1`=0, `found`=0. Pulse `start` again during the scan → ignored, a single `done` only.
- Key=3, mode=0 with `wr_en` writing entry 7 := 1 on the cycle entry 7 is compared → `out1`=8. A repeat search for key=3 → `out1`=0.
- Assert `reset` asynchronously mid-scan (between edges) → `busy`/`done`/`out1`/`found` go 0 before the next edge. No `done` follows. A key=0 mode=1 search then returns `out1`=8.
- Hold `start`=1 across the `done` cycle with key=5 mode=0 → second search accepted immediately. `done` pulses 1 cycle after each start edge with `out1`=1, with one low cycle between the pulses.
